// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson counter with direction, enable, parallel load,
// illegal-state self-correction and registered wrap / error pulses.
module ring_counter_param #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] data_out,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] RING_HOME = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_D     = 1;
    localparam logic [WIDTH-2:0] ONE_E     = 1;

    logic [WIDTH-1:0] r_data;
    logic             r_mode;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_home_in;
    logic [WIDTH-1:0] w_home_q;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-2:0] w_edges;
    logic             w_ring_ok;
    logic             w_john_ok;
    logic             w_legal;

    assign w_home_in = mode   ? '0 : RING_HOME;
    assign w_home_q  = r_mode ? '0 : RING_HOME;

    // Ring is legal when exactly one bit is set; Johnson when adjacent bit
    // pairs differ in at most one place (no wrap-around pair).
    assign w_edges   = r_data[WIDTH-1:1] ^ r_data[WIDTH-2:0];
    assign w_ring_ok = (r_data != '0) && ((r_data & (r_data - ONE_D)) == '0);
    assign w_john_ok = ((w_edges & (w_edges - ONE_E)) == '0);
    assign w_legal   = r_mode ? w_john_ok : w_ring_ok;

    always_comb begin
        w_shift = r_data;
        case ({r_mode, dir})
            2'b00:   w_shift = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            2'b01:   w_shift = {r_data[0], r_data[WIDTH-1:1]};
            2'b10:   w_shift = {r_data[WIDTH-2:0], ~r_data[WIDTH-1]};
            default: w_shift = {~r_data[0], r_data[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= w_home_in;
            r_mode <= mode;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else if (mode != r_mode) begin
            r_data <= w_home_in;
            r_mode <= mode;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else if (load) begin
            r_data <= load_val;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else if (en && !w_legal) begin
            r_data <= w_home_q;
            r_wrap <= 1'b0;
            r_err  <= 1'b1;
        end else if (en) begin
            r_data <= w_shift;
            r_wrap <= (w_shift == w_home_q);
            r_err  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end
    end

    assign data_out = r_data;
    assign wrap     = r_wrap;
    assign err      = r_err;

endmodule

// File: tb/tb_ring_counter_param.sv
// Self-checking bench for ring_counter_param (WIDTH=4): directed scenarios
// plus randomized traffic against an arithmetic reference model.
module tb_ring_counter_param;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, en, mode, dir, load;
    logic [W-1:0] load_val;
    logic [W-1:0] data_out;
    logic         wrap, err;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_q, m_mode, m_wrap, m_err;

    ring_counter_param #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val),
        .data_out(data_out), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int home(input int md);
        return (md != 0) ? 0 : 1;
    endfunction

    function automatic int bit_of(input int v, input int i);
        return (v >> i) % 2;
    endfunction

    function automatic bit legal(input int v, input int md);
        int n = 0;
        if (md == 0) begin
            for (int i = 0; i < W; i++) n += bit_of(v, i);
            return n == 1;
        end
        for (int i = 0; i < W - 1; i++) if (bit_of(v, i) != bit_of(v, i + 1)) n++;
        return n <= 1;
    endfunction

    function automatic int shifted(input int v, input int md, input int d);
        int top = bit_of(v, W - 1);
        int low = bit_of(v, 0);
        if (d == 0) return ((v * 2) % (1 << W)) + ((md != 0) ? (1 - top) : top);
        return (v / 2) + (((md != 0) ? (1 - low) : low) * (1 << (W - 1)));
    endfunction

    // One clock: drive inputs at negedge, advance the model, settle after posedge.
    task automatic cyc(input logic r, input logic e, input logic md, input logic d,
                       input logic ld, input logic [W-1:0] lv);
        @(negedge clk);
        reset = r; en = e; mode = md; dir = d; load = ld; load_val = lv;
        @(posedge clk);
        m_wrap = 0; m_err = 0;
        if (r) begin
            m_q = home(md); m_mode = md;
        end else if (int'(md) != m_mode) begin
            m_q = home(md); m_mode = md;
        end else if (ld) begin
            m_q = lv;
        end else if (e && !legal(m_q, m_mode)) begin
            m_q = home(m_mode); m_err = 1;
        end else if (e) begin
            m_q = shifted(m_q, m_mode, d);
            m_wrap = (m_q == home(m_mode)) ? 1 : 0;
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 1, 0, 0, 1, 4'b1010);
        checks++;
        if (data_out !== 4'b0001 || wrap !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: data=%b wrap=%b err=%b, want 0001 0 0", data_out, wrap, err);
        end
    endtask

    task automatic test_ring_left();
        logic [W-1:0] exp_q [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 0, '0);
            checks++;
            if (data_out !== exp_q[i] || wrap !== (i == 3) || err !== 1'b0) begin
                errors++;
                $display("FAIL ring_left[%0d]: data=%b wrap=%b err=%b, want %b %b 0",
                         i, data_out, wrap, err, exp_q[i], (i == 3));
            end
        end
    endtask

    task automatic test_ring_right();
        logic [W-1:0] exp_q [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 1, 0, '0);
            checks++;
            if (data_out !== exp_q[i] || wrap !== (i == 3) || err !== 1'b0) begin
                errors++;
                $display("FAIL ring_right[%0d]: data=%b wrap=%b err=%b, want %b %b 0",
                         i, data_out, wrap, err, exp_q[i], (i == 3));
            end
        end
    endtask

    task automatic test_johnson();
        logic [W-1:0] exp_q [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                     4'b1110, 4'b1100, 4'b1000, 4'b0000};
        cyc(1, 0, 1, 0, 0, '0);
        checks++;
        if (data_out !== 4'b0000 || wrap !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL johnson_reset: data=%b wrap=%b err=%b, want 0000 0 0", data_out, wrap, err);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 1, 0, 0, '0);
            checks++;
            if (data_out !== exp_q[i] || wrap !== (i == 7) || err !== 1'b0) begin
                errors++;
                $display("FAIL johnson[%0d]: data=%b wrap=%b err=%b, want %b %b 0",
                         i, data_out, wrap, err, exp_q[i], (i == 7));
            end
        end
    endtask

    task automatic test_ring_correction();
        logic [W-1:0] bad [2] = '{4'b0110, 4'b0000};
        cyc(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0, 1, bad[i]);
            checks++;
            if (data_out !== bad[i] || wrap !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL ring_load[%0d]: data=%b wrap=%b err=%b, want %b 0 0",
                         i, data_out, wrap, err, bad[i]);
            end
            cyc(0, 1, 0, 0, 0, '0);
            checks++;
            if (data_out !== 4'b0001 || wrap !== 1'b0 || err !== 1'b1) begin
                errors++;
                $display("FAIL ring_fix[%0d]: data=%b wrap=%b err=%b, want 0001 0 1",
                         i, data_out, wrap, err);
            end
        end
    endtask

    task automatic test_johnson_hold_illegal();
        cyc(1, 0, 1, 0, 0, '0);
        cyc(0, 0, 1, 0, 1, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0, '0);
            checks++;
            if (data_out !== 4'b0101 || wrap !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL john_hold[%0d]: data=%b wrap=%b err=%b, want 0101 0 0",
                         i, data_out, wrap, err);
            end
        end
        cyc(0, 1, 1, 0, 0, '0);
        checks++;
        if (data_out !== 4'b0000 || wrap !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL john_fix: data=%b wrap=%b err=%b, want 0000 0 1", data_out, wrap, err);
        end
    endtask

    task automatic test_mid_sequence();
        cyc(1, 0, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, 0, '0);   // 0100
        cyc(0, 1, 1, 0, 0, '0);   // mode flips with en high: home, no shift
        checks++;
        if (data_out !== 4'b0000 || wrap !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mode_toggle: data=%b wrap=%b err=%b, want 0000 0 0", data_out, wrap, err);
        end
        cyc(0, 1, 0, 0, 0, '0);   // back to ring -> 0001
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, '0);   // 1000
        cyc(1, 1, 0, 0, 1, 4'b0110);
        checks++;
        if (data_out !== 4'b0001 || wrap !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: data=%b wrap=%b err=%b, want 0001 0 0", data_out, wrap, err);
        end
        cyc(0, 1, 0, 0, 0, '0);   // 0010
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1, 0, '0);
            checks++;
            if (data_out !== 4'b0010 || wrap !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL en_low_hold[%0d]: data=%b wrap=%b err=%b, want 0010 0 0",
                         i, data_out, wrap, err);
            end
        end
        cyc(0, 1, 0, 1, 0, '0);   // dir now right: 0010 -> 0001 with wrap
        checks++;
        if (data_out !== 4'b0001 || wrap !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL dir_change: data=%b wrap=%b err=%b, want 0001 1 0", data_out, wrap, err);
        end
    endtask

    task automatic test_random();
        logic r, e, md, d, ld;
        md = 1'b0;
        cyc(1, 0, md, 0, 0, '0);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) md = ~md;
            e  = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 1);
            ld = ($urandom_range(0, 9) == 0);
            cyc(r, e, md, d, ld, W'($urandom_range(0, (1 << W) - 1)));
            checks++;
            if (data_out !== W'(m_q) || wrap !== m_wrap[0] || err !== m_err[0]) begin
                errors++;
                $display("FAIL random[%0d]: data=%b wrap=%b err=%b, want %b %0d %0d",
                         i, data_out, wrap, err, W'(m_q), m_wrap, m_err);
            end
            checks++;
            if ((wrap & err) !== 1'b0) begin
                errors++;
                $display("FAIL random_excl[%0d]: wrap=%b err=%b, want never both", i, wrap, err);
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
        m_q = 1; m_mode = 0; m_wrap = 0; m_err = 0;
        test_reset();
        test_ring_left();
        test_ring_right();
        test_johnson();
        test_ring_correction();
        test_johnson_hold_illegal();
        test_mid_sequence();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
